latch_bank_reader: RTL and testbench

//  Read-side engine for the latch-based storage bank: accepts a read request, drives the

---
 rtl/latch_bank_pkg.sv | 6 +
 rtl/piso_shift_reg.sv | 30 +++
 rtl/latch_bank_reader.sv | 65 ++++++
 tb/tb_latch_bank_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared FSM states and default geometry for the latch bank reader/writer
package latch_bank_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load shift register that emits one bit per shift and flags the final bit
module piso_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= din;
      cnt <= '0;
    end else if (shift) begin
      sr <= LSB_FIRST ? sr >> 1 : sr << 1;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  assign dout = LSB_FIRST ? sr[0] : sr[WIDTH-1];
  assign last = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/latch_bank_reader.sv
// latch_bank_reader: fetches one word from the latch bank and streams it out bit-serially
module latch_bank_reader
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1,
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              out_err
);
  localparam int LW = $clog2(RD_LAT + 1);
  state_t state, state_nx;
  logic [LW-1:0] wait_cnt;
  logic accept, capture, xfer, last;
  assign req_ready = state == IDLE;
  assign mem_rd_en = state == FETCH;
  assign out_valid = state == SHIFT;
  assign out_last = out_valid && last;
  assign accept = req_ready && req_valid;
  assign capture = mem_rd_en && wait_cnt == LW'(1);
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? FETCH : capture ? SHIFT : (xfer && out_last) ? IDLE : state;
  // out_err is decided at accept so it already covers the fetch and forces a zero word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_addr <= '0;
      wait_cnt <= '0;
      out_err <= 1'b0;
    end else if (accept) begin
      mem_addr <= req_addr;
      wait_cnt <= LW'(RD_LAT);
      out_err <= {1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH);
    end else if (mem_rd_en) begin
      wait_cnt <= wait_cnt - 1'b1;
    end else if (xfer && out_last) begin
      out_err <= 1'b0;
    end
  piso_shift_reg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_piso (
    .clk(clk),
    .rst(rst),
    .load(capture),
    .shift(xfer),
    .din(out_err ? '0 : mem_rd_data),
    .dout(out_bit),
    .last(last)
  );
endmodule

// File: tb/tb_latch_bank_reader.sv
// tb_latch_bank_reader: two reader configurations checked cycle by cycle against a transaction-level model
module tb_latch_bank_reader;
  localparam int W = 8;
  localparam int DEP [2] = '{16, 12};
  localparam int RDL [2] = '{1, 3};
  localparam int LSBF [2] = '{1, 0};

  logic clk = 1'b0;
  logic rst;
  logic req_valid [2], req_ready [2], mem_rd_en [2], out_valid [2], out_ready [2];
  logic out_bit [2], out_last [2], out_err [2];
  logic [3:0] req_addr [2], mem_addr [2];
  logic [W-1:0] mem_rd_data [2];
  logic [W-1:0] bank [2][16];

  int total = 0, bad = 0, cyc = 0;

  bit busy [2], m_err [2], want_first [2];
  int lat [2], idx [2];
  logic [3:0] m_addr [2];
  logic [W-1:0] m_word [2];

  logic [W-1:0] rx [2], last_word [2];
  int rx_n [2], last_n [2], words [2], last_cyc [2], acc_cyc [2], first_v [2], en_hi [2], err_hi [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int en_cnt;
    always @(posedge clk or posedge rst)
      if (rst) en_cnt <= 0;
      else en_cnt <= mem_rd_en[g] ? en_cnt + 1 : 0;
    // the bank only returns the true word once the read enable has been up RD_LAT cycles
    assign mem_rd_data[g] = (mem_rd_en[g] && en_cnt >= RDL[g] - 1) ? bank[g][mem_addr[g]] : ~bank[g][mem_addr[g]];
    latch_bank_reader #(.WIDTH(W), .DEPTH(DEP[g]), .ADDR_W(4), .RD_LAT(RDL[g]), .LSB_FIRST(LSBF[g] != 0)) u_dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr(req_addr[g]),
      .mem_rd_en(mem_rd_en[g]),
      .mem_addr(mem_addr[g]),
      .mem_rd_data(mem_rd_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_bit(out_bit[g]),
      .out_last(out_last[g]),
      .out_err(out_err[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    busy[k] = 0;
    lat[k] = 0;
    idx[k] = 0;
    m_err[k] = 0;
    want_first[k] = 0;
    rx_n[k] = 0;
  endtask

  task automatic model_update(input int k);
    if (!busy[k]) begin
      if (req_valid[k]) begin
        busy[k] = 1;
        lat[k] = RDL[k];
        m_addr[k] = req_addr[k];
        m_err[k] = int'(req_addr[k]) >= DEP[k];
        m_word[k] = m_err[k] ? '0 : bank[k][req_addr[k]];
        idx[k] = 0;
        acc_cyc[k] = cyc;
        want_first[k] = 1;
      end
    end else if (lat[k] > 0) begin
      lat[k]--;
    end else if (out_ready[k]) begin
      if (idx[k] == W - 1) busy[k] = 0;
      else idx[k]++;
    end
  endtask

  task automatic compare(input int k);
    bit fv;
    int b;
    fv = busy[k] && lat[k] == 0;
    if (rst) begin
      chk("rst_req_ready", k, 32'(req_ready[k]), 1);
      chk("rst_out_valid", k, 32'(out_valid[k]), 0);
      chk("rst_mem_rd_en", k, 32'(mem_rd_en[k]), 0);
      chk("rst_out_err", k, 32'(out_err[k]), 0);
    end else begin
      chk("req_ready", k, 32'(req_ready[k]), 32'(!busy[k]));
      chk("mem_rd_en", k, 32'(mem_rd_en[k]), 32'(busy[k] && lat[k] > 0));
      if (busy[k] && lat[k] > 0) chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_addr[k]));
      chk("out_valid", k, 32'(out_valid[k]), 32'(fv));
      chk("out_err", k, 32'(out_err[k]), 32'(busy[k] && m_err[k]));
      if (fv) begin
        b = LSBF[k] != 0 ? idx[k] : W - 1 - idx[k];
        chk("out_bit", k, 32'(out_bit[k]), 32'(m_word[k][b]));
        chk("out_last", k, 32'(out_last[k]), 32'(idx[k] == W - 1));
      end
    end
  endtask

  task automatic monitor(input int k);
    if (want_first[k] && out_valid[k]) begin
      first_v[k] = cyc;
      want_first[k] = 0;
    end
    if (mem_rd_en[k]) en_hi[k]++;
    if (out_valid[k] && out_ready[k]) begin
      if (rx_n[k] < W) rx[k][rx_n[k]] = out_bit[k];
      if (out_err[k]) err_hi[k]++;
      rx_n[k]++;
      if (out_last[k]) begin
        last_word[k] = rx[k];
        last_n[k] = rx_n[k];
        rx_n[k] = 0;
        words[k]++;
        last_cyc[k] = cyc;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      compare(k);
      monitor(k);
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++)
      if (rst) model_reset(k);
      else model_update(k);
    #1;
  endtask

  task automatic wait_word(input int k, input int n);
    int t;
    t = 0;
    while (words[k] < n && t < 60) begin
      step();
      t++;
    end
    chk("word_timeout", k, 32'(words[k] >= n), 1);
  endtask

  initial begin
    logic [31:0] pat;
    int i, n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k] = '0;
      out_ready[k] = 1'b1;
      words[k] = 0;
      en_hi[k] = 0;
      err_hi[k] = 0;
      for (int a = 0; a < 16; a++) bank[k][a] = 8'(a * 37 + k * 11);
      model_reset(k);
    end
    bank[0][3] = 8'hA5;
    bank[0][5] = 8'h3C;
    bank[0][0] = 8'h96;
    bank[0][15] = 8'h4E;
    bank[1][2] = 8'h81;
    bank[1][7] = 8'h0F;
    bank[1][13] = 8'hFF;
    step();
    step();
    rst = 1'b0;
    step();

    req_valid[0] = 1'b1;
    req_addr[0] = 4'd3;
    step();
    req_valid[0] = 1'b0;
    wait_word(0, 1);
    chk("a5_word", 0, 32'(last_word[0]), 32'h A5);
    chk("a5_len", 0, 32'(last_n[0]), 8);
    chk("a5_latency", 0, 32'(first_v[0] - acc_cyc[0]), 1);

    pat = 32'hB56D_3AF7;
    i = 0;
    req_valid[0] = 1'b1;
    req_addr[0] = 4'd5;
    step();
    req_valid[0] = 1'b0;
    while (words[0] < 2 && i < 80) begin
      out_ready[0] = pat[i % 32];
      step();
      i++;
    end
    out_ready[0] = 1'b1;
    chk("stall_done", 0, 32'(words[0]), 2);
    chk("stall_word", 0, 32'(last_word[0]), 32'h3C);
    chk("stall_len", 0, 32'(last_n[0]), 8);

    req_valid[0] = 1'b1;
    req_addr[0] = 4'd0;
    step();
    req_addr[0] = 4'd15;
    wait_word(0, 3);
    chk("b2b_first", 0, 32'(last_word[0]), 32'h96);
    step();
    req_valid[0] = 1'b0;
    chk("b2b_gap", 0, 32'(acc_cyc[0] - last_cyc[0]), 2);
    chk("b2b_addr", 0, 32'(mem_addr[0]), 15);
    wait_word(0, 4);
    chk("b2b_second", 0, 32'(last_word[0]), 32'h4E);

    req_valid[1] = 1'b1;
    req_addr[1] = 4'd13;
    step();
    req_valid[1] = 1'b0;
    chk("oor_err_fetch", 1, 32'(out_err[1]), 1);
    wait_word(1, 1);
    chk("oor_word", 1, 32'(last_word[1]), 0);
    chk("oor_err_all", 1, 32'(err_hi[1]), 8);
    step();
    chk("oor_err_clear", 1, 32'(out_err[1]), 0);

    en_hi[1] = 0;
    req_valid[1] = 1'b1;
    req_addr[1] = 4'd2;
    step();
    req_valid[1] = 1'b0;
    wait_word(1, 2);
    chk("lat3_en_cycles", 1, 32'(en_hi[1]), 3);
    chk("lat3_word", 1, 32'(last_word[1]), 32'h81);
    chk("lat3_latency", 1, 32'(first_v[1] - acc_cyc[1]), 3);
    req_valid[1] = 1'b1;
    req_addr[1] = 4'd7;
    step();
    req_valid[1] = 1'b0;
    wait_word(1, 3);
    chk("msb_first_order", 1, 32'(last_word[1]), 32'hF0);

    req_valid[0] = 1'b1;
    req_addr[0] = 4'd3;
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_valid", 0, 32'(out_valid[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req_ready", 0, 32'(req_ready[0]), 1);
    chk("async_out_valid", 0, 32'(out_valid[0]), 0);
    chk("async_out_bit", 0, 32'(out_bit[0]), 0);
    chk("async_out_last", 0, 32'(out_last[0]), 0);
    chk("async_out_err", 0, 32'(out_err[0]), 0);
    chk("async_mem_rd_en", 0, 32'(mem_rd_en[0]), 0);
    chk("async_mem_addr", 0, 32'(mem_addr[0]), 0);
    for (int k = 0; k < 2; k++) model_reset(k);
    step();
    step();
    rst = 1'b0;
    n = words[0];
    req_valid[0] = 1'b1;
    req_addr[0] = 4'd5;
    step();
    req_valid[0] = 1'b0;
    wait_word(0, n + 1);
    chk("post_rst_word", 0, 32'(last_word[0]), 32'h3C);
    chk("post_rst_len", 0, 32'(last_n[0]), 8);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
